// File: rtl/sparcy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sparcy_pkg
//  Description : Shared definitions for the memory pipeline stage.
//                Holds the memory-format op3 encodings, the memory FSM state
//                enum, the access-size enum and small op3 decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package sparcy_pkg;

    // Format field value that selects the memory instruction format
    localparam logic [1:0] c_OP_MEM   = 2'b11;

    // Memory opcodes (op3 field)
    localparam logic [5:0] c_OP3_LD   = 6'b000000;
    localparam logic [5:0] c_OP3_LDUB = 6'b000001;
    localparam logic [5:0] c_OP3_LDUH = 6'b000010;
    localparam logic [5:0] c_OP3_LDSB = 6'b001001;
    localparam logic [5:0] c_OP3_LDSH = 6'b001010;
    localparam logic [5:0] c_OP3_ST   = 6'b000100;
    localparam logic [5:0] c_OP3_STB  = 6'b000101;
    localparam logic [5:0] c_OP3_STH  = 6'b000110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    function automatic logic op3_is_mem(input logic [5:0] op3);
        case (op3)
            c_OP3_LD, c_OP3_LDUB, c_OP3_LDUH, c_OP3_LDSB, c_OP3_LDSH,
            c_OP3_ST, c_OP3_STB, c_OP3_STH: op3_is_mem = 1'b1;
            default:                        op3_is_mem = 1'b0;
        endcase
    endfunction

    function automatic logic op3_is_store(input logic [5:0] op3);
        case (op3)
            c_OP3_ST, c_OP3_STB, c_OP3_STH: op3_is_store = 1'b1;
            default:                        op3_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic op3_is_signed(input logic [5:0] op3);
        case (op3)
            c_OP3_LDSB, c_OP3_LDSH: op3_is_signed = 1'b1;
            default:                op3_is_signed = 1'b0;
        endcase
    endfunction

    function automatic mem_size_t op3_size(input logic [5:0] op3);
        case (op3)
            c_OP3_LDUB, c_OP3_LDSB, c_OP3_STB: op3_size = SZ_BYTE;
            c_OP3_LDUH, c_OP3_LDSH, c_OP3_STH: op3_size = SZ_HALF;
            default:                           op3_size = SZ_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_align
//  Description : Combinational byte-lane steering for a 32-bit big-endian
//                data bus. Generates byte enables and lane-replicated store
//                data, and extracts/extends the addressed lane of load data.
//  Ports       : i_size     access size (byte/half/word)
//                i_addr_lo  low two address bits (already size-aligned)
//                i_signed   sign-extend the extracted load value
//                i_wdata    raw store data (value in the low bits)
//                i_rdata    raw 32-bit load data from memory
//                o_be       byte enables, bit3 = byte address 0
//                o_wdata    store data replicated across all lanes
//                o_rdata    extracted, zero/sign-extended load value
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import sparcy_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Big-endian: byte address 0 lives in the most significant lane
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
    end

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_be    = 4'b1000 >> i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_be    = i_addr_lo[1] ? 4'b0011 : 4'b1100;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_signed & w_half[15]}}, w_half};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory pipeline stage. Non-memory instructions pass to the
//                write-back register with one cycle of latency. Memory ops
//                are latched and run through an IDLE/REQ/WAIT handshake on
//                the data-memory port while the upstream register is stalled.
//  Build macro : MEM_ALIGN_TRAP_EN - when defined, misaligned half/word
//                accesses issue no request and pulse the trap output; when
//                undefined, the trap port is absent and the offending low
//                address bits are forced to zero.
//  Ports       : clk, reset          clock, synchronous active-high reset
//                in_*                instruction from execute/memory register
//                stall               hold the upstream register
//                dmem_*              data-memory request/response port
//                out_*               result to the write-back register
//                trap                misaligned-access pulse (macro builds)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import sparcy_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        in_op,
    input  logic [5:0]        in_op3,
    input  logic [DATA_W-1:0] in_alures,
    input  logic [DATA_W-1:0] in_valD,
    input  logic [4:0]        in_regD,
    input  logic              in_wen,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              out_valid,
    output logic [4:0]        out_regD,
    output logic              out_wen,
    output logic [DATA_W-1:0] out_wbdata
`ifdef MEM_ALIGN_TRAP_EN
    ,
    output logic              trap
`endif
);

    mem_state_t        r_state_q, w_state_d;

    // Latched memory instruction
    logic [ADDR_W-1:0] r_addr_q,  w_addr_d;
    logic [DATA_W-1:0] r_wdata_q, w_wdata_d;
    logic [5:0]        r_op3_q,   w_op3_d;
    logic [4:0]        r_regD_q,  w_regD_d;
    logic              r_wen_q,   w_wen_d;

    // Write-back register
    logic              r_out_valid_q,  w_out_valid_d;
    logic [4:0]        r_out_regD_q,   w_out_regD_d;
    logic              r_out_wen_q,    w_out_wen_d;
    logic [DATA_W-1:0] r_out_wbdata_q, w_out_wbdata_d;
`ifdef MEM_ALIGN_TRAP_EN
    logic              r_trap_q,       w_trap_d;
    logic              w_misalign;
`endif

    logic              w_in_is_mem;
    logic              w_accept_mem;
    mem_size_t         w_in_size;
    logic [ADDR_W-1:0] w_in_addr;
    logic              w_held_store;
    logic [3:0]        w_lane_be;
    logic [DATA_W-1:0] w_lane_wdata;
    logic [DATA_W-1:0] w_lane_rdata;

    // ------------------------------------------------------------------
    // Incoming instruction decode
    // ------------------------------------------------------------------
    assign w_in_is_mem = in_valid && (in_op == c_OP_MEM) && op3_is_mem(in_op3);
    assign w_in_size   = op3_size(in_op3);

    always_comb begin
        w_in_addr = in_alures[ADDR_W-1:0];
`ifndef MEM_ALIGN_TRAP_EN
        // Without trapping, a misaligned access is silently rounded down
        if (w_in_size == SZ_HALF) begin
            w_in_addr[0] = 1'b0;
        end else if (w_in_size == SZ_WORD) begin
            w_in_addr[1:0] = 2'b00;
        end
`endif
    end

`ifdef MEM_ALIGN_TRAP_EN
    assign w_misalign   = ((w_in_size == SZ_HALF) && in_alures[0]) ||
                          ((w_in_size == SZ_WORD) && (in_alures[1:0] != 2'b00));
    assign w_accept_mem = w_in_is_mem && !w_misalign;
`else
    assign w_accept_mem = w_in_is_mem;
`endif

    assign w_held_store = op3_is_store(r_op3_q);

    // Steering works on the latched instruction so bus signals stay stable
    // for the whole request phase.
    mem_lane_align u_lane (
        .i_size    (op3_size(r_op3_q)),
        .i_addr_lo (r_addr_q[1:0]),
        .i_signed  (op3_is_signed(r_op3_q)),
        .i_wdata   (r_wdata_q),
        .i_rdata   (dmem_rdata),
        .o_be      (w_lane_be),
        .o_wdata   (w_lane_wdata),
        .o_rdata   (w_lane_rdata)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= IDLE;
            r_addr_q       <= '0;
            r_wdata_q      <= '0;
            r_op3_q        <= '0;
            r_regD_q       <= '0;
            r_wen_q        <= 1'b0;
            r_out_valid_q  <= 1'b0;
            r_out_regD_q   <= '0;
            r_out_wen_q    <= 1'b0;
            r_out_wbdata_q <= '0;
`ifdef MEM_ALIGN_TRAP_EN
            r_trap_q       <= 1'b0;
`endif
        end else begin
            r_state_q      <= w_state_d;
            r_addr_q       <= w_addr_d;
            r_wdata_q      <= w_wdata_d;
            r_op3_q        <= w_op3_d;
            r_regD_q       <= w_regD_d;
            r_wen_q        <= w_wen_d;
            r_out_valid_q  <= w_out_valid_d;
            r_out_regD_q   <= w_out_regD_d;
            r_out_wen_q    <= w_out_wen_d;
            r_out_wbdata_q <= w_out_wbdata_d;
`ifdef MEM_ALIGN_TRAP_EN
            r_trap_q       <= w_trap_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE: if (w_accept_mem) w_state_d = REQ;
            REQ:  if (dmem_gnt)     w_state_d = w_held_store ? IDLE : WAIT;
            WAIT: if (dmem_rvalid)  w_state_d = IDLE;
            default:                w_state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        stall          = 1'b0;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_be        = 4'b0000;
        dmem_wdata     = '0;
        w_addr_d       = r_addr_q;
        w_wdata_d      = r_wdata_q;
        w_op3_d        = r_op3_q;
        w_regD_d       = r_regD_q;
        w_wen_d        = r_wen_q;
        w_out_valid_d  = 1'b0;
        w_out_wen_d    = 1'b0;
        w_out_regD_d   = r_out_regD_q;
        w_out_wbdata_d = r_out_wbdata_q;
`ifdef MEM_ALIGN_TRAP_EN
        w_trap_d       = 1'b0;
`endif
        case (r_state_q)
            IDLE: begin
                if (w_accept_mem) begin
                    stall     = 1'b1;
                    w_addr_d  = w_in_addr;
                    w_wdata_d = in_valD;
                    w_op3_d   = in_op3;
                    w_regD_d  = in_regD;
                    w_wen_d   = in_wen;
                end
`ifdef MEM_ALIGN_TRAP_EN
                else if (w_in_is_mem) begin
                    // Misaligned: retire immediately without touching memory
                    w_out_valid_d = 1'b1;
                    w_out_regD_d  = in_regD;
                    w_trap_d      = 1'b1;
                end
`endif
                else if (in_valid) begin
                    w_out_valid_d  = 1'b1;
                    w_out_regD_d   = in_regD;
                    w_out_wen_d    = in_wen;
                    w_out_wbdata_d = in_alures;
                end
            end
            REQ: begin
                dmem_req   = 1'b1;
                dmem_we    = w_held_store;
                dmem_addr  = {r_addr_q[ADDR_W-1:2], 2'b00};
                dmem_be    = w_lane_be;
                dmem_wdata = w_lane_wdata;
                // A granted store finishes here, so upstream may advance
                stall      = !(dmem_gnt && w_held_store);
                if (dmem_gnt && w_held_store) begin
                    w_out_valid_d = 1'b1;
                    w_out_regD_d  = r_regD_q;
                end
            end
            WAIT: begin
                stall = !dmem_rvalid;
                if (dmem_rvalid) begin
                    w_out_valid_d  = 1'b1;
                    w_out_regD_d   = r_regD_q;
                    w_out_wen_d    = r_wen_q;
                    w_out_wbdata_d = w_lane_rdata;
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
        // Combinational outputs read zero while reset is held
        if (reset) begin
            stall      = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            dmem_addr  = '0;
            dmem_be    = 4'b0000;
            dmem_wdata = '0;
        end
    end

    assign out_valid  = r_out_valid_q;
    assign out_regD   = r_out_regD_q;
    assign out_wen    = r_out_wen_q;
    assign out_wbdata = r_out_wbdata_q;
`ifdef MEM_ALIGN_TRAP_EN
    assign trap       = r_trap_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Self-checking bench for mem_stage. Directed scenarios plus
//                randomized instruction streams compared against an
//                arithmetic reference model of lane steering and extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [5:0]  in_op3;
    logic [31:0] in_alures;
    logic [31:0] in_valD;
    logic [4:0]  in_regD;
    logic        in_wen;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic [4:0]  out_regD;
    logic        out_wen;
    logic [31:0] out_wbdata;
`ifdef MEM_ALIGN_TRAP_EN
    logic        trap;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Observations recorded by the drivers, judged by the test tasks
    logic        obs_acc_stall, obs_done_stall, obs_req_first, obs_we;
    logic        obs_req_in_wait, obs_reaccept;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;
    int          obs_unstable, obs_stall_bad, obs_outv_bad;
    logic        obs_out_valid, obs_out_wen;
    logic [4:0]  obs_out_regd;
    logic [31:0] obs_out_wbdata;

    mem_stage #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_op       (in_op),
        .in_op3      (in_op3),
        .in_alures   (in_alures),
        .in_valD     (in_valD),
        .in_regD     (in_regD),
        .in_wen      (in_wen),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .out_valid   (out_valid),
        .out_regD    (out_regD),
        .out_wen     (out_wen),
        .out_wbdata  (out_wbdata)
`ifdef MEM_ALIGN_TRAP_EN
        ,
        .trap        (trap)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic bit m_is_mem(input logic [5:0] op3);
        return op3 inside {6'b000000, 6'b000001, 6'b000010, 6'b001001,
                           6'b001010, 6'b000100, 6'b000101, 6'b000110};
    endfunction

    function automatic bit m_is_store(input logic [5:0] op3);
        return op3 inside {6'b000100, 6'b000101, 6'b000110};
    endfunction

    function automatic bit m_is_signed(input logic [5:0] op3);
        return op3 inside {6'b001001, 6'b001010};
    endfunction

    function automatic int m_size(input logic [5:0] op3);
        if (op3 inside {6'b000000, 6'b000100}) return 4;
        if (op3 inside {6'b000010, 6'b001010, 6'b000110}) return 2;
        return 1;
    endfunction

    // Byte offset of the access inside its word after rounding down
    function automatic int m_off(input logic [5:0] op3, input logic [31:0] addr);
        int sz = m_size(op3);
        return int'(addr % 4) / sz * sz;
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] addr);
        return addr - (addr % 4);
    endfunction

    function automatic logic [3:0] m_be(input logic [5:0] op3, input logic [31:0] addr);
        logic [3:0] be = 4'b0000;
        int off = m_off(op3, addr);
        for (int l = off; l < off + m_size(op3); l++) be[3 - l] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] op3, input logic [31:0] vald);
        logic [31:0] w = 32'h0;
        int sz = m_size(op3);
        for (int l = 0; l < 4; l++)
            w = w | (((vald >> (8 * (sz - 1 - (l % sz)))) & 32'hFF) << (8 * (3 - l)));
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] op3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int          sz   = m_size(op3);
        int          off  = m_off(op3, addr);
        logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        logic [31:0] v    = (rdata >> (8 * (4 - off - sz))) & mask;
        if (m_is_signed(op3) && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Drivers (entered and left at a negative clock edge)
    // ------------------------------------------------------------------
    task automatic issue_alu(input logic [1:0] op, input logic [5:0] op3,
                             input logic [31:0] alures, input logic [4:0] regd,
                             input logic wen);
        in_valid = 1'b1; in_op = op; in_op3 = op3; in_alures = alures;
        in_valD = $urandom; in_regD = regd; in_wen = wen;
        #1 obs_acc_stall = stall;
        @(negedge clk);
        obs_out_valid = out_valid; obs_out_wen = out_wen;
        obs_out_regd = out_regD;   obs_out_wbdata = out_wbdata;
        in_valid = 1'b0;
    endtask

    task automatic issue_mem(input logic [5:0] op3, input logic [31:0] addr,
                             input logic [31:0] vald, input logic [4:0] regd,
                             input logic wen, input int gnt_dly, input int rv_dly,
                             input logic [31:0] rdata);
        in_valid = 1'b1; in_op = 2'b11; in_op3 = op3; in_alures = addr;
        in_valD = vald; in_regD = regd; in_wen = wen;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1 obs_acc_stall = stall;
        @(negedge clk);
        obs_unstable = 0; obs_stall_bad = 0; obs_outv_bad = 0;
        obs_req_first = dmem_req; obs_be = dmem_be; obs_addr = dmem_addr;
        obs_wdata = dmem_wdata;   obs_we = dmem_we;
        obs_req_in_wait = 1'b0;
        for (int k = 0; k <= gnt_dly; k++) begin
            if (dmem_req !== 1'b1 || dmem_be !== obs_be || dmem_addr !== obs_addr ||
                dmem_wdata !== obs_wdata || dmem_we !== obs_we) obs_unstable++;
            if (out_valid !== 1'b0) obs_outv_bad++;
            if (k == gnt_dly) begin
                dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
            end else begin
                // stray rvalid during the request phase must be ignored
                dmem_gnt = 1'b0; dmem_rvalid = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
            end
            #1;
            if (k == gnt_dly) obs_done_stall = stall;
            else if (stall !== 1'b1) obs_stall_bad++;
            @(negedge clk);
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        if (!m_is_store(op3)) begin
            obs_req_in_wait = dmem_req;
            for (int k = 0; k <= rv_dly; k++) begin
                if (out_valid !== 1'b0) obs_outv_bad++;
                if (k == rv_dly) begin
                    dmem_rvalid = 1'b1; dmem_rdata = rdata; dmem_gnt = 1'b0;
                end else begin
                    dmem_rvalid = 1'b0; dmem_rdata = $urandom; dmem_gnt = 1'($urandom_range(0, 1));
                end
                #1;
                if (k == rv_dly) obs_done_stall = stall;
                else if (stall !== 1'b1) obs_stall_bad++;
                @(negedge clk);
            end
            dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
        end
        obs_out_valid = out_valid; obs_out_wen = out_wen;
        obs_out_regd = out_regD;   obs_out_wbdata = out_wbdata;
        // the held instruction was still presented at the completion edge
        obs_reaccept = dmem_req;
        in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; in_op = 2'b11; in_op3 = 6'b000000;
        in_alures = 32'h40; in_valD = 32'h0; in_regD = 5'd3; in_wen = 1'b1;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else n_pass++;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", dmem_req); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0 || out_wen !== 1'b0)
            $display("FAIL reset_out_flags: got valid=%b wen=%b expected 0/0", out_valid, out_wen); else n_pass++;
        n_total++; if (out_wbdata !== 32'h0 || out_regD !== 5'd0)
            $display("FAIL reset_out_data: got wb=%h rd=%0d expected 0/0", out_wbdata, out_regD); else n_pass++;
        n_total++; if (dmem_be !== 4'b0 || dmem_addr !== 32'h0 || dmem_we !== 1'b0)
            $display("FAIL reset_bus: got be=%b addr=%h we=%b expected zero", dmem_be, dmem_addr, dmem_we); else n_pass++;
`ifdef MEM_ALIGN_TRAP_EN
        n_total++; if (trap !== 1'b0) $display("FAIL reset_trap: got %b expected 0", trap); else n_pass++;
`endif
        reset = 1'b0; in_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu;
        issue_alu(2'b10, 6'b000000, 32'h1234, 5'd5, 1'b1);
        n_total++; if (obs_acc_stall !== 1'b0) $display("FAIL alu_stall: got %b expected 0", obs_acc_stall); else n_pass++;
        n_total++; if (obs_out_wbdata !== 32'h1234) $display("FAIL alu_wbdata: got %h expected 00001234", obs_out_wbdata); else n_pass++;
        n_total++; if (obs_out_valid !== 1'b1 || obs_out_wen !== 1'b1 || obs_out_regd !== 5'd5)
            $display("FAIL alu_out: got valid=%b wen=%b rd=%0d expected 1/1/5", obs_out_valid, obs_out_wen, obs_out_regd); else n_pass++;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0 || out_wen !== 1'b0)
            $display("FAIL alu_idle_out: got valid=%b wen=%b expected 0/0", out_valid, out_wen); else n_pass++;
    endtask

    task automatic test_ldsb;
        issue_mem(6'b001001, 32'h101, 32'h0, 5'd7, 1'b1, 2, 1, 32'h00F0_0000);
        n_total++; if (obs_be !== 4'b0100 || obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_req_first !== 1'b1)
            $display("FAIL ldsb_req: got be=%b addr=%h we=%b req=%b expected 0100/00000100/0/1", obs_be, obs_addr, obs_we, obs_req_first); else n_pass++;
        n_total++; if (obs_unstable != 0 || obs_stall_bad != 0 || obs_acc_stall !== 1'b1 || obs_done_stall !== 1'b0)
            $display("FAIL ldsb_stall: got unstable=%0d stallbad=%0d acc=%b done=%b expected 0/0/1/0", obs_unstable, obs_stall_bad, obs_acc_stall, obs_done_stall); else n_pass++;
        n_total++; if (obs_req_in_wait !== 1'b0) $display("FAIL ldsb_req_wait: got %b expected 0", obs_req_in_wait); else n_pass++;
        n_total++; if (obs_out_wbdata !== 32'hFFFF_FFF0) $display("FAIL ldsb_wbdata: got %h expected fffffff0", obs_out_wbdata); else n_pass++;
        n_total++; if (obs_out_valid !== 1'b1 || obs_out_wen !== 1'b1 || obs_out_regd !== 5'd7 || obs_reaccept !== 1'b0 || obs_outv_bad != 0)
            $display("FAIL ldsb_out: got valid=%b wen=%b rd=%0d reacc=%b early=%0d expected 1/1/7/0/0", obs_out_valid, obs_out_wen, obs_out_regd, obs_reaccept, obs_outv_bad); else n_pass++;
    endtask

    task automatic test_sth;
        issue_mem(6'b000110, 32'h202, 32'h0000_ABCD, 5'd9, 1'b1, 0, 0, 32'h0);
        n_total++; if (obs_be !== 4'b0011 || obs_wdata !== 32'hABCD_ABCD || obs_we !== 1'b1)
            $display("FAIL sth_req: got be=%b wdata=%h we=%b expected 0011/abcdabcd/1", obs_be, obs_wdata, obs_we); else n_pass++;
        n_total++; if (obs_acc_stall !== 1'b1 || obs_done_stall !== 1'b0)
            $display("FAIL sth_stall: got acc=%b done=%b expected 1/0", obs_acc_stall, obs_done_stall); else n_pass++;
        n_total++; if (obs_out_valid !== 1'b1 || obs_out_wen !== 1'b0 || obs_reaccept !== 1'b0)
            $display("FAIL sth_out: got valid=%b wen=%b reacc=%b expected 1/0/0", obs_out_valid, obs_out_wen, obs_reaccept); else n_pass++;
    endtask

    task automatic test_misaligned;
`ifdef MEM_ALIGN_TRAP_EN
        in_valid = 1'b1; in_op = 2'b11; in_op3 = 6'b000000; in_alures = 32'h3;
        in_valD = 32'h0; in_regD = 5'd4; in_wen = 1'b1;
        #1;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL trap_req_now: got %b expected 0", dmem_req); else n_pass++;
        @(negedge clk);
        n_total++; if (trap !== 1'b1 || out_valid !== 1'b1 || out_wen !== 1'b0 || dmem_req !== 1'b0)
            $display("FAIL trap_pulse: got trap=%b valid=%b wen=%b req=%b expected 1/1/0/0", trap, out_valid, out_wen, dmem_req); else n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        n_total++; if (trap !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0)
            $display("FAIL trap_after: got trap=%b stall=%b req=%b expected 0/0/0", trap, stall, dmem_req); else n_pass++;
`else
        issue_mem(6'b000000, 32'h3, 32'h0, 5'd4, 1'b1, 0, 0, 32'h1122_3344);
        n_total++; if (obs_addr !== 32'h0 || obs_be !== 4'b1111)
            $display("FAIL misal_ld_req: got addr=%h be=%b expected 00000000/1111", obs_addr, obs_be); else n_pass++;
        n_total++; if (obs_out_wbdata !== 32'h1122_3344) $display("FAIL misal_ld_data: got %h expected 11223344", obs_out_wbdata); else n_pass++;
        issue_mem(6'b000010, 32'h203, 32'h0, 5'd6, 1'b1, 1, 0, 32'h1122_8344);
        n_total++; if (obs_addr !== 32'h200 || obs_be !== 4'b0011 || obs_out_wbdata !== 32'h0000_8344)
            $display("FAIL misal_lduh: got addr=%h be=%b wb=%h expected 00000200/0011/00008344", obs_addr, obs_be, obs_out_wbdata); else n_pass++;
`endif
    endtask

    task automatic test_reset_in_wait;
        in_valid = 1'b1; in_op = 2'b11; in_op3 = 6'b000000; in_alures = 32'h80;
        in_valD = 32'h0; in_regD = 5'd2; in_wen = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        n_total++; if (stall !== 1'b1 || dmem_req !== 1'b0)
            $display("FAIL rstw_in_wait: got stall=%b req=%b expected 1/0", stall, dmem_req); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_total++; if (stall !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rstw_idle: got stall=%b valid=%b expected 0/0", stall, out_valid); else n_pass++;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        n_total++; if (out_valid !== 1'b0 || out_wen !== 1'b0 || dmem_req !== 1'b0)
            $display("FAIL rstw_stale: got valid=%b wen=%b req=%b expected 0/0/0", out_valid, out_wen, dmem_req); else n_pass++;
    endtask

    task automatic test_random;
        logic [5:0] mem_ops [8] = '{6'b000000, 6'b000001, 6'b000010, 6'b001001,
                                    6'b001010, 6'b000100, 6'b000101, 6'b000110};
        for (int it = 0; it < 60; it++) begin
            logic [5:0]  op3;
            logic [1:0]  op;
            logic [31:0] addr, vald, rdata;
            logic [4:0]  regd;
            logic        wen;
            addr = $urandom; vald = $urandom; rdata = $urandom;
            regd = 5'($urandom); wen = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                op  = 2'($urandom);
                op3 = 6'($urandom);
                if (op == 2'b11) while (m_is_mem(op3)) op3 = 6'($urandom);
                issue_alu(op, op3, addr, regd, wen);
                n_total++; if (obs_acc_stall !== 1'b0 || obs_out_valid !== 1'b1 || obs_out_wen !== wen ||
                               obs_out_regd !== regd || obs_out_wbdata !== addr)
                    $display("FAIL rnd_alu[%0d]: got stall=%b v=%b wen=%b rd=%0d wb=%h expected 0/1/%b/%0d/%h",
                             it, obs_acc_stall, obs_out_valid, obs_out_wen, obs_out_regd, obs_out_wbdata, wen, regd, addr);
                else n_pass++;
            end else begin
                op3 = mem_ops[$urandom_range(0, 7)];
`ifdef MEM_ALIGN_TRAP_EN
                addr = addr - (addr % 32'(m_size(op3)));
`endif
                issue_mem(op3, addr, vald, regd, wen, $urandom_range(0, 3), $urandom_range(0, 3), rdata);
                n_total++; if (obs_acc_stall !== 1'b1 || obs_stall_bad != 0 || obs_done_stall !== 1'b0 || obs_outv_bad != 0)
                    $display("FAIL rnd_stall[%0d]: got acc=%b bad=%0d done=%b early=%0d expected 1/0/0/0",
                             it, obs_acc_stall, obs_stall_bad, obs_done_stall, obs_outv_bad);
                else n_pass++;
                n_total++; if (obs_req_first !== 1'b1 || obs_unstable != 0 || obs_addr !== m_addr(addr) ||
                               obs_be !== m_be(op3, addr) || obs_we !== m_is_store(op3))
                    $display("FAIL rnd_req[%0d]: got req=%b unst=%0d addr=%h be=%b we=%b expected 1/0/%h/%b/%b",
                             it, obs_req_first, obs_unstable, obs_addr, obs_be, obs_we, m_addr(addr), m_be(op3, addr), m_is_store(op3));
                else n_pass++;
                if (m_is_store(op3)) begin
                    n_total++; if (obs_wdata !== m_wdata(op3, vald) || obs_out_wen !== 1'b0)
                        $display("FAIL rnd_store[%0d]: got wdata=%h wen=%b expected %h/0", it, obs_wdata, obs_out_wen, m_wdata(op3, vald));
                    else n_pass++;
                end else begin
                    n_total++; if (obs_req_in_wait !== 1'b0 || obs_out_wbdata !== m_load(op3, addr, rdata) || obs_out_wen !== wen)
                        $display("FAIL rnd_load[%0d]: got reqw=%b wb=%h wen=%b expected 0/%h/%b",
                                 it, obs_req_in_wait, obs_out_wbdata, obs_out_wen, m_load(op3, addr, rdata), wen);
                    else n_pass++;
                end
                n_total++; if (obs_out_valid !== 1'b1 || obs_out_regd !== regd || obs_reaccept !== 1'b0)
                    $display("FAIL rnd_done[%0d]: got v=%b rd=%0d reacc=%b expected 1/%0d/0", it, obs_out_valid, obs_out_regd, obs_reaccept, regd);
                else n_pass++;
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; in_op = 2'b00; in_op3 = 6'b0; in_alures = 32'h0;
        in_valD = 32'h0; in_regD = 5'd0; in_wen = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0; reset = 1'b1;
        test_reset();
        test_alu();
        test_ldsb();
        test_sth();
        test_misaligned();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
